// File: rtl/proc_multicycle_ctrl.sv
// Multicycle control unit for TinyRV1: sequences fetch/decode/execute/memory
// over a shared-memory datapath and raises one retire pulse per instruction.
module proc_multicycle_ctrl #(
  parameter int unsigned MUL_CYCLES_MAX = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        br_eq,
  input  logic        mem_resp_val,
  input  logic        mul_done,
  output logic        mem_req_val,
  output logic        mem_wen,
  output logic        mem_addr_sel,
  output logic        ir_en,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic [1:0]  imm_type,
  output logic        op2_sel,
  output logic        rf_wen,
  output logic [1:0]  wb_sel,
  output logic        mul_start,
  output logic        trace_val,
  output logic        halt
);

  localparam int unsigned CNT_W = (MUL_CYCLES_MAX < 2) ? 1 : $clog2(MUL_CYCLES_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES_MAX - 1);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MUL, S_MEM, S_HALT} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_ADDI, OP_MUL, OP_LW, OP_SW, OP_JAL, OP_JR, OP_BNE, OP_ILL
  } op_e;
  typedef enum logic [1:0] {PC_SEQ, PC_TGT, PC_RS1} pc_sel_e;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_MUL, WB_PC4} wb_e;

  typedef struct packed {
    logic    mem_req_val;
    logic    mem_wen;
    logic    mem_addr_sel;
    logic    ir_en;
    logic    pc_en;
    pc_sel_e pc_sel;
    imm_e    imm_type;
    logic    op2_sel;
    logic    rf_wen;
    wb_e     wb_sel;
    logic    mul_start;
    logic    trace_val;
    logic    halt;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  op_e              op;
  ctrl_t            ctrl;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [11:0] imm_i;
  logic        unused_rs1;

  assign opcode     = inst[6:0];
  assign rd         = inst[11:7];
  assign funct3     = inst[14:12];
  assign funct7     = inst[31:25];
  assign imm_i      = inst[31:20];
  assign unused_rs1 = ^inst[19:15];

  always_comb begin
    op = OP_ILL;
    case (opcode)
      7'b0110011: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000)      op = OP_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0000001) op = OP_MUL;
      end
      7'b0010011: if (funct3 == 3'b000) op = OP_ADDI;
      7'b0000011: if (funct3 == 3'b010) op = OP_LW;
      7'b0100011: if (funct3 == 3'b010) op = OP_SW;
      7'b1101111: op = OP_JAL;
      7'b1100111: if (funct3 == 3'b000 && rd == 5'd0 && imm_i == 12'd0) op = OP_JR;
      7'b1100011: if (funct3 == 3'b001) op = OP_BNE;
      default:    op = OP_ILL;
    endcase
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path leaves one unassigned (no latches).
    ctrl      = '0;
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;

    case (state_q)
      S_FETCH: begin
        ctrl.mem_req_val = 1'b1;
        if (mem_resp_val) begin
          ctrl.ir_en = 1'b1;
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        case (op)
          OP_JAL: begin
            ctrl.imm_type  = IMM_J;
            ctrl.rf_wen    = 1'b1;
            ctrl.wb_sel    = WB_PC4;
            ctrl.pc_en     = 1'b1;
            ctrl.pc_sel    = PC_TGT;
            ctrl.trace_val = 1'b1;
            state_d        = S_FETCH;
          end
          OP_JR: begin
            ctrl.pc_en     = 1'b1;
            ctrl.pc_sel    = PC_RS1;
            ctrl.trace_val = 1'b1;
            state_d        = S_FETCH;
          end
          OP_MUL: begin
            ctrl.mul_start = 1'b1;
            mul_cnt_d      = '0;
            state_d        = S_MUL;
          end
          OP_ILL:  state_d = S_HALT;
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (op)
          OP_ADD, OP_ADDI: begin
            ctrl.op2_sel   = (op == OP_ADDI);
            ctrl.imm_type  = IMM_I;
            ctrl.rf_wen    = 1'b1;
            ctrl.wb_sel    = WB_ALU;
            ctrl.pc_en     = 1'b1;
            ctrl.pc_sel    = PC_SEQ;
            ctrl.trace_val = 1'b1;
            state_d        = S_FETCH;
          end
          OP_BNE: begin
            ctrl.imm_type  = IMM_B;
            ctrl.pc_en     = 1'b1;
            ctrl.pc_sel    = br_eq ? PC_SEQ : PC_TGT;
            ctrl.trace_val = 1'b1;
            state_d        = S_FETCH;
          end
          OP_LW, OP_SW: begin
            ctrl.imm_type = (op == OP_SW) ? IMM_S : IMM_I;
            ctrl.op2_sel  = 1'b1;
            state_d       = S_MEM;
          end
          default: state_d = S_HALT;
        endcase
      end

      S_MUL: begin
        if (mul_done) begin
          ctrl.rf_wen    = 1'b1;
          ctrl.wb_sel    = WB_MUL;
          ctrl.pc_en     = 1'b1;
          ctrl.pc_sel    = PC_SEQ;
          ctrl.trace_val = 1'b1;
          state_d        = S_FETCH;
        end else if (mul_cnt_q == CNT_LAST) begin
          // The multiplier has had its full budget of MUL cycles.
          state_d = S_HALT;
        end else begin
          mul_cnt_d = mul_cnt_q + CNT_W'(1);
        end
      end

      S_MEM: begin
        ctrl.imm_type     = (op == OP_SW) ? IMM_S : IMM_I;
        ctrl.op2_sel      = 1'b1;
        ctrl.mem_req_val  = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
        ctrl.mem_wen      = (op == OP_SW);
        if (mem_resp_val) begin
          if (op == OP_LW) begin
            ctrl.rf_wen = 1'b1;
            ctrl.wb_sel = WB_MEM;
          end
          ctrl.pc_en     = 1'b1;
          ctrl.pc_sel    = PC_SEQ;
          ctrl.trace_val = 1'b1;
          state_d        = S_FETCH;
        end
      end

      S_HALT:  ctrl.halt = 1'b1;
      default: state_d = S_HALT;
    endcase

    // Held in reset the state already reads FETCH; mask it so no request leaks out.
    if (!rst) ctrl = '0;
  end

  assign mem_req_val  = ctrl.mem_req_val;
  assign mem_wen      = ctrl.mem_wen;
  assign mem_addr_sel = ctrl.mem_addr_sel;
  assign ir_en        = ctrl.ir_en;
  assign pc_en        = ctrl.pc_en;
  assign pc_sel       = ctrl.pc_sel;
  assign imm_type     = ctrl.imm_type;
  assign op2_sel      = ctrl.op2_sel;
  assign rf_wen       = ctrl.rf_wen;
  assign wb_sel       = ctrl.wb_sel;
  assign mul_start    = ctrl.mul_start;
  assign trace_val    = ctrl.trace_val;
  assign halt         = ctrl.halt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      mul_cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

endmodule

// File: tb/tb_proc_multicycle_ctrl.sv
// Self-checking bench for proc_multicycle_ctrl: per-instruction cycle counts and
// retire-cycle controls checked against a per-opcode CPI/control model.
module tb_proc_multicycle_ctrl;

  localparam int MAXC = 8;

  typedef enum int {I_ADD, I_ADDI, I_MUL, I_LW, I_SW, I_JAL, I_JR, I_BNE, I_ILL} kind_e;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst = '0;
  logic        br_eq = 1'b0;
  logic        mem_resp_val = 1'b0;
  logic        mul_done = 1'b0;
  logic        mem_req_val, mem_wen, mem_addr_sel, ir_en, pc_en;
  logic [1:0]  pc_sel, imm_type, wb_sel;
  logic        op2_sel, rf_wen, mul_start, trace_val, halt;

  int n_cmp = 0;
  int n_err = 0;

  wire [14:0] ctl_vec = {mem_req_val, mem_wen, mem_addr_sel, ir_en, pc_en, pc_sel,
                         imm_type, op2_sel, rf_wen, wb_sel, mul_start, trace_val};

  proc_multicycle_ctrl #(.MUL_CYCLES_MAX(MAXC)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst         (inst),
    .br_eq        (br_eq),
    .mem_resp_val (mem_resp_val),
    .mul_done     (mul_done),
    .mem_req_val  (mem_req_val),
    .mem_wen      (mem_wen),
    .mem_addr_sel (mem_addr_sel),
    .ir_en        (ir_en),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .imm_type     (imm_type),
    .op2_sel      (op2_sel),
    .rf_wen       (rf_wen),
    .wb_sel       (wb_sel),
    .mul_start    (mul_start),
    .trace_val    (trace_val),
    .halt         (halt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] encode(input kind_e k);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    imm = 12'($urandom);
    case (k)
      I_ADD:   return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      I_MUL:   return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
      I_ADDI:  return {imm, rs1, 3'b000, rd, 7'b0010011};
      I_LW:    return {imm, rs1, 3'b010, rd, 7'b0000011};
      I_SW:    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      I_JAL:   return {25'($urandom), 7'b1101111};
      I_JR:    return {12'h000, rs1, 3'b000, 5'd0, 7'b1100111};
      I_BNE:   return {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b1100011};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Runs one instruction from its first FETCH cycle, acting as memory and
  // multiplier, then compares what was seen with the CPI/control model.
  task automatic run_instr(input kind_e k, input logic [31:0] word, input int fw,
                           input int mw, input int mk, input logic beq);
    int cyc = 0, req_run = 0, req_phase = 0, mcnt = 0;
    int fetch_len = 0, mem_len = 0, ir_cnt = 0, pc_cnt = 0, rf_cnt = 0, ms_cnt = 0, hs_bad = 0;
    bit in_mul = 0, retired = 0, halted = 0, exp_halt = 0;
    logic r_rf = 0, r_op2 = 0;
    logic [1:0] r_wb = '0, r_pc = '0, r_imm = '0;
    int exp_cyc;
    logic e_rf = 0, e_op2 = 0;
    logic [1:0] e_wb = '0, e_pc = '0, e_imm = '0;
    string tag;
    tag = k.name();

    case (k)
      I_JAL:  begin exp_cyc = fw + 2; e_rf = 1; e_wb = 2'd3; e_pc = 2'd1; e_imm = 2'd3; end
      I_JR:   begin exp_cyc = fw + 2; e_pc = 2'd2; end
      I_ADD:  begin exp_cyc = fw + 3; e_rf = 1; end
      I_ADDI: begin exp_cyc = fw + 3; e_rf = 1; e_op2 = 1; end
      I_BNE:  begin exp_cyc = fw + 3; e_pc = beq ? 2'd0 : 2'd1; e_imm = 2'd2; end
      I_LW:   begin exp_cyc = fw + mw + 4; e_rf = 1; e_wb = 2'd1; e_op2 = 1; end
      I_SW:   begin exp_cyc = fw + mw + 4; e_op2 = 1; e_imm = 2'd1; end
      I_MUL: begin
        if (mk < MAXC) begin exp_cyc = fw + mk + 3; e_rf = 1; e_wb = 2'd2; end
        else begin exp_halt = 1; exp_cyc = fw + MAXC + 3; end
      end
      default: begin exp_halt = 1; exp_cyc = fw + 3; end
    endcase

    while (!retired && !halted && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        inst  = word;
        br_eq = beq;
      end
      if (mem_req_val) begin
        if (req_run == 0) req_phase++;
        req_run++;
        if (req_phase == 1) fetch_len++; else mem_len++;
        mem_resp_val = (req_run == ((req_phase == 1) ? fw : mw) + 1);
      end else begin
        req_run = 0;
        mem_resp_val = 1'($urandom_range(0, 1));
      end
      if (in_mul) begin
        mul_done = (mcnt == mk);
        mcnt++;
      end else begin
        mul_done = 1'($urandom_range(0, 1));
      end
      if (mul_start) in_mul = 1;
      #1;
      if (mem_req_val) begin
        if (req_phase == 1 && (mem_addr_sel !== 1'b0 || mem_wen !== 1'b0)) hs_bad++;
        if (req_phase == 2 && (mem_addr_sel !== 1'b1 || mem_wen !== (k == I_SW))) hs_bad++;
        if (req_phase > 2) hs_bad++;
      end
      if (ir_en) ir_cnt++;
      if (pc_en) pc_cnt++;
      if (rf_wen) rf_cnt++;
      if (mul_start) ms_cnt++;
      if (trace_val) begin
        retired = 1;
        r_rf = rf_wen; r_wb = wb_sel; r_pc = pc_sel; r_imm = imm_type; r_op2 = op2_sel;
      end
      if (halt) halted = 1;
    end

    n_cmp++;
    if (halted != exp_halt) begin n_err++; $display("FAIL %s halt: got %0d want %0d", tag, halted, exp_halt); end
    n_cmp++;
    if (retired == exp_halt) begin n_err++; $display("FAIL %s retire: got %0d want %0d", tag, retired, !exp_halt); end
    n_cmp++;
    if (cyc != exp_cyc) begin n_err++; $display("FAIL %s cycles: got %0d want %0d", tag, cyc, exp_cyc); end
    n_cmp++;
    if (ir_cnt != 1) begin n_err++; $display("FAIL %s ir_en_count: got %0d want 1", tag, ir_cnt); end
    n_cmp++;
    if (fetch_len != fw + 1) begin n_err++; $display("FAIL %s fetch_len: got %0d want %0d", tag, fetch_len, fw + 1); end
    n_cmp++;
    if (hs_bad != 0) begin n_err++; $display("FAIL %s req_controls: got %0d bad cycles want 0", tag, hs_bad); end
    n_cmp++;
    if (ms_cnt != int'(k == I_MUL)) begin n_err++; $display("FAIL %s mul_start_count: got %0d want %0d", tag, ms_cnt, int'(k == I_MUL)); end
    if (!exp_halt) begin
      n_cmp++;
      if (pc_cnt != 1) begin n_err++; $display("FAIL %s pc_en_count: got %0d want 1", tag, pc_cnt); end
      n_cmp++;
      if (rf_cnt != int'(e_rf)) begin n_err++; $display("FAIL %s rf_wen_count: got %0d want %0d", tag, rf_cnt, e_rf); end
      n_cmp++;
      if (r_rf !== e_rf) begin n_err++; $display("FAIL %s rf_wen: got %0d want %0d", tag, r_rf, e_rf); end
      n_cmp++;
      if (r_wb !== e_wb) begin n_err++; $display("FAIL %s wb_sel: got %0d want %0d", tag, r_wb, e_wb); end
      n_cmp++;
      if (r_pc !== e_pc) begin n_err++; $display("FAIL %s pc_sel: got %0d want %0d", tag, r_pc, e_pc); end
      n_cmp++;
      if (r_imm !== e_imm) begin n_err++; $display("FAIL %s imm_type: got %0d want %0d", tag, r_imm, e_imm); end
      n_cmp++;
      if (r_op2 !== e_op2) begin n_err++; $display("FAIL %s op2_sel: got %0d want %0d", tag, r_op2, e_op2); end
      if (k == I_LW || k == I_SW) begin
        n_cmp++;
        if (mem_len != mw + 1) begin n_err++; $display("FAIL %s mem_len: got %0d want %0d", tag, mem_len, mw + 1); end
      end
    end else begin
      n_cmp++;
      if (pc_cnt != 0 || rf_cnt != 0) begin
        n_err++; $display("FAIL %s halt_writes: got pc_en %0d rf_wen %0d want 0 0", tag, pc_cnt, rf_cnt);
      end
    end
  endtask

  task automatic hold_halt(input string tag);
    repeat (5) begin
      @(negedge clk);
      mem_resp_val = 1'($urandom_range(0, 1));
      mul_done     = 1'($urandom_range(0, 1));
      br_eq        = 1'($urandom_range(0, 1));
      inst         = $urandom;
      #1;
      n_cmp++;
      if (halt !== 1'b1) begin n_err++; $display("FAIL %s halt_sticky: got %0d want 1", tag, halt); end
      n_cmp++;
      if (ctl_vec !== 15'h0) begin n_err++; $display("FAIL %s halt_outputs: got %h want 0", tag, ctl_vec); end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      mem_resp_val = 1'($urandom_range(0, 1));
      mul_done     = 1'($urandom_range(0, 1));
      br_eq        = 1'($urandom_range(0, 1));
      inst         = $urandom;
      #1;
      n_cmp++;
      if ({halt, ctl_vec} !== 16'h0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", {halt, ctl_vec}); end
      @(negedge clk);
    end
    mem_resp_val = 1'b0;
    mul_done     = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_add();
    run_instr(I_ADD, encode(I_ADD), 0, 0, 0, 1'b0);
    run_instr(I_ADDI, encode(I_ADDI), 0, 0, 0, 1'b1);
  endtask

  task automatic test_jr_loop();
    repeat (4) run_instr(I_JR, encode(I_JR), 0, 0, 0, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_bne();
    logic [31:0] w;
    w = encode(I_BNE);
    run_instr(I_BNE, w, 0, 0, 0, 1'b1);
    run_instr(I_BNE, w, 0, 0, 0, 1'b0);
  endtask

  task automatic test_lw_delay();
    run_instr(I_LW, encode(I_LW), 0, 3, 0, 1'b0);
    run_instr(I_SW, encode(I_SW), 2, 0, 0, 1'b0);
  endtask

  task automatic test_mul();
    run_instr(I_MUL, encode(I_MUL), 0, 0, 5, 1'b0);
    run_instr(I_MUL, encode(I_MUL), 0, 0, 0, 1'b0);
    run_instr(I_MUL, encode(I_MUL), 1, 0, MAXC - 1, 1'b0);
  endtask

  task automatic test_watchdog();
    run_instr(I_MUL, encode(I_MUL), 0, 0, 1000, 1'b0);
    hold_halt("watchdog");
    do_reset();
  endtask

  task automatic test_illegal();
    logic [31:0] words [6];
    words[0] = 32'hFFFF_FFFF;
    words[1] = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    words[2] = {12'h000, 5'd1, 3'b000, 5'd1, 7'b1100111};
    words[3] = {12'h004, 5'd1, 3'b000, 5'd0, 7'b1100111};
    words[4] = {12'h010, 5'd1, 3'b000, 5'd3, 7'b0000011};
    words[5] = {7'b0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
    for (int i = 0; i < 6; i++) begin
      run_instr(I_ILL, words[i], i % 2, 0, 0, 1'b0);
      hold_halt("illegal");
      do_reset();
    end
  endtask

  task automatic test_reset_midfetch();
    @(negedge clk);
    mem_resp_val = 1'b0;
    #1;
    n_cmp++;
    if (mem_req_val !== 1'b1) begin n_err++; $display("FAIL midfetch_req_before: got %0d want 1", mem_req_val); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_req_val !== 1'b0) begin n_err++; $display("FAIL midfetch_req_dropped: got %0d want 0", mem_req_val); end
    n_cmp++;
    if ({halt, ctl_vec} !== 16'h0) begin n_err++; $display("FAIL midfetch_outputs: got %h want 0", {halt, ctl_vec}); end
    do_reset();
    run_instr(I_ADD, encode(I_ADD), 0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    kind_e k;
    for (int i = 0; i < 60; i++) begin
      k = kind_e'($urandom_range(0, 7));
      run_instr(k, encode(k), $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(0, MAXC - 1), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_jr_loop();
    test_bne();
    test_lw_delay();
    test_mul();
    test_watchdog();
    test_illegal();
    test_reset_midfetch();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
